// File: rtl/ps2_host_transceiver_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_transceiver_fifo
// Description : PS/2 host transceiver with filtered pins, timeouts, a command
//               transmit path and a show-ahead receive FIFO.
//               Optional: PS2_PARITY_CHECK_EN enables receive parity checking.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_transceiver_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int RX_FIFO_DEPTH  = 16,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int IDLE_CYCLES    = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       cmd_data,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    output logic                             cmd_done,
    output logic                             cmd_error,
    output logic [7:0]                       rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
    output logic                             rx_overflow,
    output logic                             rx_frame_error,
    inout  wire                              PS2_CLK,
    inout  wire                              PS2_DAT
);

    localparam int c_ptr_w   = $clog2(RX_FIFO_DEPTH);
    localparam int c_tmr_max = (INHIBIT_CYCLES > TIMEOUT_CYCLES)
                             ? ((INHIBIT_CYCLES > IDLE_CYCLES) ? INHIBIT_CYCLES : IDLE_CYCLES)
                             : ((TIMEOUT_CYCLES > IDLE_CYCLES) ? TIMEOUT_CYCLES : IDLE_CYCLES);
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
    localparam logic [c_tmr_w-1:0] c_idle_max   = c_tmr_w'(IDLE_CYCLES);
    localparam logic [c_tmr_w-1:0] c_inh_last   = c_tmr_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tout_last  = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_ptr_w:0]   c_depth      = (c_ptr_w + 1)'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_RX           = 3'd1,
        S_TX_INHIBIT   = 3'd2,
        S_TX_START     = 3'd3,
        S_TX_DATA      = 3'd4,
        S_TX_ACK       = 3'd5,
        S_TX_WAIT_IDLE = 3'd6
    } state_t;

    // ---- pin synchronise + filter; index 0 = clock line, 1 = data line ----
    logic [1:0] w_pin, w_filt, w_fall, w_edge;
    assign w_pin = {PS2_DAT, PS2_CLK};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            logic       r_s1, r_s2, r_f, r_fl, r_e;
            logic [7:0] r_fcnt;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s1   <= 1'b1;
                    r_s2   <= 1'b1;
                    r_f    <= 1'b1;
                    r_fl   <= 1'b0;
                    r_e    <= 1'b0;
                    r_fcnt <= '0;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                    r_fl <= 1'b0;
                    r_e  <= 1'b0;
                    if (r_s2 == r_f) begin
                        r_fcnt <= '0;
                    end else if (r_fcnt == 8'(FILTER_LEN - 1)) begin
                        r_fcnt <= '0;
                        r_f    <= r_s2;
                        r_e    <= 1'b1;
                        r_fl   <= ~r_s2;
                    end else begin
                        r_fcnt <= r_fcnt + 8'd1;
                    end
                end
            end
            assign w_filt[gi] = r_f;
            assign w_fall[gi] = r_fl;
            assign w_edge[gi] = r_e;
        end
    endgenerate

    logic w_clk_f, w_dat_f, w_clk_fall, w_clk_edge;
    assign w_clk_f    = w_filt[0];
    assign w_dat_f    = w_filt[1];
    assign w_clk_fall = w_fall[0];
    assign w_clk_edge = w_edge[0];

    // ---- control FSM ----
    state_t               r_state, w_state_nxt;
    logic [c_tmr_w-1:0]   r_tmr, w_tmr_nxt, w_gap_tmr;
    logic [3:0]           r_bit, w_bit_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_clk_oe, w_clk_oe_nxt, r_dat_oe, w_dat_oe_nxt;
    logic                 r_cmd_ready, w_cmd_ready_nxt;
    logic                 r_cmd_done, w_cmd_done_nxt, r_cmd_error, w_cmd_error_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 w_push, w_rx_good, w_gap_expire;

    assign w_gap_tmr    = w_clk_edge ? '0 : r_tmr + c_tmr_w'(1);
    assign w_gap_expire = !w_clk_edge && (r_tmr == c_tout_last);

`ifdef PS2_PARITY_CHECK_EN
    assign w_rx_good = w_dat_f & (^{r_shift, r_par});
`else
    assign w_rx_good = w_dat_f;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_dat_oe    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_cmd_error <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_par       <= w_par_nxt;
            r_clk_oe    <= w_clk_oe_nxt;
            r_dat_oe    <= w_dat_oe_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_cmd_done  <= w_cmd_done_nxt;
            r_cmd_error <= w_cmd_error_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tmr_nxt       = r_tmr;
        w_bit_nxt       = r_bit;
        w_shift_nxt     = r_shift;
        w_par_nxt       = r_par;
        w_dat_oe_nxt    = r_dat_oe;
        w_cmd_done_nxt  = 1'b0;
        w_cmd_error_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_push          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_tmr != c_idle_max) w_tmr_nxt = r_tmr + c_tmr_w'(1);
                // A command beats a simultaneous device start; the device retransmits.
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt = S_TX_INHIBIT;
                    w_tmr_nxt   = '0;
                    w_shift_nxt = cmd_data;
                    w_par_nxt   = ~^cmd_data;
                end else if (w_clk_fall && !w_dat_f) begin
                    w_state_nxt = S_RX;
                    w_tmr_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_RX: begin
                w_tmr_nxt = w_gap_tmr;
                if (w_clk_fall) begin
                    w_bit_nxt = r_bit + 4'd1;
                    if (r_bit < 4'd8) begin
                        w_shift_nxt = {w_dat_f, r_shift[7:1]};
                    end else if (r_bit == 4'd8) begin
                        w_par_nxt = w_dat_f;
                    end else begin
                        w_push          = w_rx_good;
                        w_frame_err_nxt = !w_rx_good;
                        w_state_nxt     = S_IDLE;
                        w_tmr_nxt       = '0;
                    end
                end else if (w_gap_expire) begin
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_tmr_nxt       = '0;
                end
            end
            S_TX_INHIBIT: begin
                if (r_tmr == c_inh_last) begin
                    w_state_nxt  = S_TX_START;
                    w_tmr_nxt    = '0;
                    w_dat_oe_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + c_tmr_w'(1);
                end
            end
            S_TX_START: begin
                w_state_nxt = S_TX_DATA;
                w_tmr_nxt   = '0;
                w_bit_nxt   = '0;
            end
            S_TX_DATA: begin
                w_tmr_nxt = w_gap_tmr;
                if (w_clk_fall) begin
                    w_bit_nxt = r_bit + 4'd1;
                    if (r_bit < 4'd8) begin
                        w_dat_oe_nxt = ~r_shift[r_bit[2:0]];
                    end else if (r_bit == 4'd8) begin
                        w_dat_oe_nxt = ~r_par;
                    end else begin
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = S_TX_ACK;
                    end
                end else if (w_gap_expire) begin
                    w_cmd_error_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_tmr_nxt       = '0;
                end
            end
            S_TX_ACK: begin
                w_tmr_nxt = w_gap_tmr;
                if (w_clk_fall) begin
                    w_cmd_done_nxt  = !w_dat_f;
                    w_cmd_error_nxt = w_dat_f;
                    w_state_nxt     = S_TX_WAIT_IDLE;
                end else if (w_gap_expire) begin
                    w_cmd_error_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_tmr_nxt       = '0;
                end
            end
            S_TX_WAIT_IDLE: begin
                if (w_clk_f && w_dat_f) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
        // Data line may only be pulled low while a command is being shifted out.
        if (!(w_state_nxt inside {S_TX_START, S_TX_DATA})) w_dat_oe_nxt = 1'b0;
        w_clk_oe_nxt    = (w_state_nxt == S_TX_INHIBIT);
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && (w_tmr_nxt == c_idle_max);
    end

    // ---- receive FIFO (show-ahead) ----
    logic [7:0]         r_mem [RX_FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr, r_rd;
    logic [c_ptr_w:0]   r_count;
    logic               r_overflow, w_pop, w_full, w_wr_en;

    assign w_pop   = (r_count != '0) && rx_ready;
    assign w_full  = (r_count == c_depth);
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= r_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr_en) r_wr <= r_wr + c_ptr_w'(1);
            if (w_pop)   r_rd <= r_rd + c_ptr_w'(1);
            if (w_wr_en && !w_pop)      r_count <= r_count + (c_ptr_w + 1)'(1);
            else if (!w_wr_en && w_pop) r_count <= r_count - (c_ptr_w + 1)'(1);
        end
    end

    assign rx_valid       = (r_count != '0);
    assign rx_data        = rx_valid ? r_mem[r_rd] : 8'h00;
    assign rx_count       = r_count;
    assign rx_overflow    = r_overflow;
    assign rx_frame_error = r_frame_err;
    assign cmd_ready      = r_cmd_ready;
    assign cmd_done       = r_cmd_done;
    assign cmd_error      = r_cmd_error;
    assign PS2_CLK        = r_clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT        = r_dat_oe ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
